bcd_scan_display: RTL and testbench
===================================

BCD_SCAN_DISPLAY -- requirements
Module: bcd_scan_display

Interface
REQ-001 The block SHALL have parameter SCAN_DIV, default 4, giving the number of clocks each digit is displayed (legal range 1..256).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port clr, input, 1 bit: synchronous, active-low reset.
REQ-004 The block SHALL have port load, input, 1 bit: capture strobe for digits.
REQ-005 The block SHALL have port digits, input, 16 bits: four BCD digits from the cascaded mod-10 counters; [3:0] is digit 0 (least significant), and [15:12] is digit 3.
REQ-006 The block SHALL have port blank_lz, input, 1 bit: leading-zero blanking enable.
REQ-007 The block SHALL have port seg, output, 7 bits: active-high segments; seg[0]=a through seg[6]=g.
REQ-008 The block SHALL have port an, output, 4 bits: one-hot active-high digit enable; an[i] selects digit i.
REQ-009 The block SHALL have port ovf, output, 1 bit: flag that the last captured value held a non-BCD digit.

Function
REQ-010 On an edge with load=1, the block SHALL capture digits into a 16-bit shadow register; the display path SHALL use only the shadow register.
REQ-011 A prescaler SHALL count 0..SCAN_DIV-1 and wrap; on the edge where it equals SCAN_DIV-1, the digit index SHALL advance 0->1->2->3->0.
REQ-012 With SCAN_DIV=1, the index SHALL advance every clock.
REQ-013 seg and an SHALL be registered, computed each edge from the pre-edge index and shadow, so an and seg always refer to the same digit.
REQ-014 an SHALL equal one-hot(index) delayed one clock; exactly one bit of an SHALL be high at all times.
REQ-015 The decode SHALL be (gfedcba hex): 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
REQ-016 Digit values 10..15 SHALL decode to 40 (dash).
REQ-017 With blank_lz=1, digit i (i=3..1) SHALL decode to 00 when it and every higher digit equal 0; digit 0 SHALL never be blanked.
REQ-018 With blank_lz=0, no digit SHALL be blanked.
REQ-019 On a load edge, ovf SHALL be set to 1 if any captured digit >9 and cleared to 0 otherwise; it SHALL hold between loads.
REQ-020 A load SHALL NOT disturb the prescaler or index; the new value SHALL appear on seg one clock after the capturing edge.
REQ-021 blank_lz SHALL be sampled every clock, not latched by load.

Reset
REQ-022 On an edge with clr=0, the block SHALL set shadow=0, prescaler=0, index=0, an=0001, seg=3F and ovf=0, overriding load.
REQ-023 After clr returns high, digit 0 SHALL be displayed for SCAN_DIV clocks before digit 1.
REQ-024 A reset mid-scan SHALL abandon the current dwell without a partial digit.

Structure
REQ-025 A shared package bcd_disp_pkg SHALL hold NDIG=4, the ten digit segment constants, SEG_DASH=40 and SEG_BLANK=00.
REQ-026 The digit decode SHALL be a combinational sub-module bcd_to_7seg (4-bit in, 7-bit out) instantiated once on the muxed digit.
REQ-027 The block SHALL contain no gated clocks or latches; the prescaler width SHALL be derived from SCAN_DIV.

Verification
REQ-028 Reset: with clr=0 for 2 clocks, then load=0 -> an=0001, seg=3F, ovf=0, and an advances to 0010 after 4 clocks.
REQ-029 Scan: load digits=16'h1985, SCAN_DIV=4 -> seg sequence 6D,7F,6F,06, each held for 4 clocks, with an 0001,0010,0100,1000 in lockstep.
REQ-030 Blanking: load 16'h0070 with blank_lz=1 -> digit3=00, digit2=00, digit1=07, digit0=3F; with blank_lz=0 -> 3F,3F,07,3F.
REQ-031 Overflow: load 16'h00A3 -> digit1=40 and ovf=1; then load 16'h0003 -> ovf=0.
REQ-032 Mid-scan load and reset: load during digit2 dwell -> new digit2 value on the next clock with dwell length unchanged; clr=0 during digit3 -> an=0001 and seg=3F on the next edge.

Source files
------------

// File: rtl/bcd_disp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bcd_disp_pkg
// Description : Shared constants for the multiplexed BCD seven-segment
//               display: digit count, segment patterns (gfedcba, active
//               high) and the digit-index to one-hot helper.
// Revision    : 1.0 - initial release
// ============================================================================
package bcd_disp_pkg;

    localparam int NDIG  = 4;
    localparam int IDX_W = 2;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_DASH  = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Digit index to one-hot anode enable
    function automatic logic [NDIG-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
        logic [NDIG-1:0] one;
        one = NDIG'(1);
        return one << idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_to_7seg.sv
`default_nettype none
// ============================================================================
// Module      : bcd_to_7seg
// Description : Combinational BCD to seven-segment decoder. Codes 10..15
//               are not valid BCD and show a dash.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_to_7seg
    import bcd_disp_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    // Pure lookup; every code maps to a pattern so no latch is possible
    always_comb begin
        seg = SEG_DASH;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/bcd_scan_display.sv
`default_nettype none
// ============================================================================
// Module      : bcd_scan_display
// Description : Four-digit multiplexed seven-segment driver. Captures four
//               BCD digits into a shadow register on load, scans them with a
//               SCAN_DIV-clock dwell per digit, optionally blanks leading
//               zeros, and flags non-BCD captured digits.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_scan_display
    import bcd_disp_pkg::*;
#(
    parameter int SCAN_DIV = 4
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        load,
    input  logic [15:0] digits,
    input  logic        blank_lz,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic        ovf
);

    // A 1-bit prescaler is kept even for SCAN_DIV=1; it simply stays at 0
    localparam int              PRESC_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(SCAN_DIV - 1);

    logic [15:0]        r_shadow;
    logic               r_ovf;
    logic [PRESC_W-1:0] r_presc;
    logic [IDX_W-1:0]   r_idx;
    logic [NDIG-1:0]    r_an;
    logic [6:0]         r_seg;

    logic [3:0]         w_digit;
    logic [6:0]         w_dec;
    logic               w_blank;
    logic               w_bad;
    logic               w_presc_wrap;

    assign w_presc_wrap = (r_presc == PRESC_MAX);
    assign w_digit      = r_shadow[{r_idx, 2'b00} +: 4];

    // Non-BCD detect on the incoming word, used only when it is captured
    always_comb begin
        w_bad = 1'b0;
        for (int i = 0; i < NDIG; i++) begin
            if (digits[i*4 +: 4] > 4'd9) begin
                w_bad = 1'b1;
            end
        end
    end

    // Leading-zero blank: current digit and every higher one are zero; never digit 0
    always_comb begin
        w_blank = blank_lz && (r_idx != '0);
        for (int i = 1; i < NDIG; i++) begin
            if ((i >= int'(r_idx)) && (r_shadow[i*4 +: 4] != 4'd0)) begin
                w_blank = 1'b0;
            end
        end
    end

    bcd_to_7seg u_dec (
        .bcd (w_digit),
        .seg (w_dec)
    );

    // Shadow capture and overflow flag; ovf holds between loads
    always_ff @(posedge clk) begin
        if (!clr) begin
            r_shadow <= '0;
            r_ovf    <= 1'b0;
        end else if (load) begin
            r_shadow <= digits;
            r_ovf    <= w_bad;
        end
    end

    // Prescaler and digit index; load never touches the scan timing
    always_ff @(posedge clk) begin
        if (!clr) begin
            r_presc <= '0;
            r_idx   <= '0;
        end else if (w_presc_wrap) begin
            r_presc <= '0;
            r_idx   <= r_idx + 1'b1;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    // Registered outputs from the pre-edge index so an and seg stay paired
    always_ff @(posedge clk) begin
        if (!clr) begin
            r_an  <= idx_to_onehot('0);
            r_seg <= SEG_0;
        end else begin
            r_an  <= idx_to_onehot(r_idx);
            r_seg <= w_blank ? SEG_BLANK : w_dec;
        end
    end

    assign seg = r_seg;
    assign an  = r_an;
    assign ovf = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_bcd_scan_display.sv
`default_nettype none
// ============================================================================
// Module      : tb_bcd_scan_display
// Description : Directed self-checking bench for bcd_scan_display with
//               SCAN_DIV=4: reset, scan order, blanking, overflow, mid-scan
//               load and mid-scan reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_scan_display;

    logic        clk = 1'b0;
    logic        clr;
    logic        load;
    logic [15:0] digits;
    logic        blank_lz;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        ovf;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    bcd_scan_display #(.SCAN_DIV(4)) dut (
        .clk      (clk),
        .clr      (clr),
        .load     (load),
        .digits   (digits),
        .blank_lz (blank_lz),
        .seg      (seg),
        .an       (an),
        .ovf      (ovf)
    );

    // Advance one clock and settle just after the edge
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_val(input string tag, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, act, exp);
    endtask

    // One reset edge, then release; next edge is scan edge 1
    task automatic restart;
        clr  = 1'b0;
        load = 1'b0;
        tick();
        clr  = 1'b1;
    endtask

    // Load on scan edge 1
    task automatic load_word(input logic [15:0] w);
        digits = w;
        load   = 1'b1;
        tick();
        load   = 1'b0;
    endtask

    // Edges 2..16 after a load on edge 1; exp_segs = {d3,d2,d1,d0}
    task automatic scan_check(input string tag, input logic [27:0] exp_segs);
        logic [3:0] one;
        int         idx;
        one = 4'b0001;
        for (int e = 2; e <= 16; e++) begin
            idx = ((e - 1) / 4) % 4;
            tick();
            check_val({tag, "_seg"}, {9'd0, seg}, {9'd0, exp_segs[idx*7 +: 7]});
            check_val({tag, "_an"},  {12'd0, an}, {12'd0, one << idx});
        end
    endtask

    initial begin
        // Reset held two clocks; load during reset must be ignored
        clr      = 1'b0;
        load     = 1'b1;
        digits   = 16'hFFFF;
        blank_lz = 1'b0;
        tick();
        tick();
        check_val("rst_an",  {12'd0, an},  16'h0001);
        check_val("rst_seg", {9'd0, seg},  16'h003F);
        check_val("rst_ovf", {15'd0, ovf}, 16'h0000);

        clr    = 1'b1;
        load   = 1'b0;
        digits = 16'h0000;
        for (int k = 1; k <= 4; k++) tick();
        check_val("rst_dwell_an",  {12'd0, an}, 16'h0001);
        check_val("rst_dwell_seg", {9'd0, seg}, 16'h003F);
        tick();
        check_val("rst_adv_an",    {12'd0, an}, 16'h0002);

        // Scan order 1985
        restart();
        load_word(16'h1985);
        check_val("load_lat_seg", {9'd0, seg}, 16'h003F);
        scan_check("scan1985", {7'h06, 7'h6F, 7'h7F, 7'h6D});

        // Leading-zero blanking on and off
        restart();
        blank_lz = 1'b1;
        load_word(16'h0070);
        scan_check("blank_on", {7'h00, 7'h00, 7'h07, 7'h3F});
        restart();
        blank_lz = 1'b0;
        load_word(16'h0070);
        scan_check("blank_off", {7'h3F, 7'h3F, 7'h07, 7'h3F});

        // Overflow set, held, cleared
        restart();
        load_word(16'h00A3);
        check_val("ovf_set", {15'd0, ovf}, 16'h0001);
        scan_check("ovf_scan", {7'h3F, 7'h3F, 7'h40, 7'h4F});
        check_val("ovf_hold", {15'd0, ovf}, 16'h0001);
        load_word(16'h0003);
        check_val("ovf_clr", {15'd0, ovf}, 16'h0000);

        // Mid-scan load during digit 2 dwell
        restart();
        load_word(16'h1985);
        for (int e = 2; e <= 9; e++) tick();
        check_val("mid_pre_an",  {12'd0, an}, 16'h0004);
        check_val("mid_pre_seg", {9'd0, seg}, 16'h006F);
        digits = 16'h4321;
        load   = 1'b1;
        tick();
        load   = 1'b0;
        check_val("mid_ld_seg",  {9'd0, seg}, 16'h006F);
        tick();
        check_val("mid_new_seg", {9'd0, seg}, 16'h004F);
        check_val("mid_new_an",  {12'd0, an}, 16'h0004);
        tick();
        check_val("mid_dwell_seg", {9'd0, seg}, 16'h004F);
        check_val("mid_dwell_an",  {12'd0, an}, 16'h0004);
        tick();
        check_val("mid_d3_seg", {9'd0, seg}, 16'h0066);
        check_val("mid_d3_an",  {12'd0, an}, 16'h0008);
        tick();

        // Reset in digit 3 dwell
        clr = 1'b0;
        tick();
        check_val("mrst_an",  {12'd0, an},  16'h0001);
        check_val("mrst_seg", {9'd0, seg},  16'h003F);
        check_val("mrst_ovf", {15'd0, ovf}, 16'h0000);
        clr = 1'b1;
        for (int k = 1; k <= 4; k++) tick();
        check_val("mrst_dwell_an", {12'd0, an}, 16'h0001);
        tick();
        check_val("mrst_adv_an",   {12'd0, an}, 16'h0002);
        check_val("mrst_adv_seg",  {9'd0, seg}, 16'h003F);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
